// File: rtl/cla_pkg.sv
// Shared types and width helpers for the sequential carry-lookahead adder.
package cla_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} cla_state_t;

  localparam int DEF_NBITS = 4;
  localparam int DEF_BLOCK = 4;

  function automatic int nblk(input int nbits, input int block);
    return (block > 0) ? nbits / block : 0;
  endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational BLOCK-bit carry-lookahead slice.
module cla_block
  import cla_pkg::*;
#(
  parameter int BLOCK = DEF_BLOCK
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co
);

  logic [BLOCK-1:0] g;
  logic [BLOCK-1:0] p;
  logic [BLOCK:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is a flat OR of generate terms gated by the propagates above them
  always_comb begin : lookahead
    logic t;
    t = 1'b0;
    c = '0;
    c[0] = ci;
    for (int k = 0; k < BLOCK; k++) begin
      t = ci;
      for (int j = 0; j <= k; j++) t = t & p[j];
      c[k+1] = t;
      for (int j = 0; j <= k; j++) begin
        t = g[j];
        for (int m = j + 1; m <= k; m++) t = t & p[m];
        c[k+1] = c[k+1] | t;
      end
    end
  end

  assign s  = p ^ c[BLOCK-1:0];
  assign co = c[BLOCK];

endmodule

// File: rtl/cla_seq_adder.sv
// Handshaked N-bit adder, one CLA slice per clock with a rippled carry register.
// Define CLA_OVERFLOW_EN to add the signed-overflow output ovf.
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int nBITS = DEF_NBITS,
  parameter int BLOCK = DEF_BLOCK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [nBITS-1:0] ain,
  input  logic [nBITS-1:0] bin,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [nBITS-1:0] sum,
  output logic             cout
`ifdef CLA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int NBLK = nblk(nBITS, BLOCK);
  localparam int CW   = $clog2(NBLK) + 1;
  localparam int MSB  = nBITS - 1;
  localparam logic [CW-1:0] LAST = CW'(NBLK - 1);

  generate
    if (nBITS == 0 || (nBITS % BLOCK) != 0) begin : g_bad_cfg
      $error("cla_seq_adder: nBITS must be a positive multiple of BLOCK");
    end
  endgenerate

  cla_state_t       state, state_n;
  logic [nBITS-1:0] a_lat, b_lat;
  logic             carry;
  logic [CW-1:0]    idx;
  logic             last;
  logic [BLOCK-1:0] a_sl, b_sl, s_sl;
  logic             co_sl;

  assign last = (idx == LAST);
  assign a_sl = a_lat[idx*BLOCK +: BLOCK];
  assign b_sl = b_lat[idx*BLOCK +: BLOCK];

  cla_block #(
    .BLOCK(BLOCK)
  ) u_blk (
    .a (a_sl),
    .b (b_sl),
    .ci(carry),
    .s (s_sl),
    .co(co_sl)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (in_valid)  state_n = CALC;
      CALC:    if (last)      state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Handshake flags are registered copies of the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      in_ready  <= (state_n == IDLE);
      out_valid <= (state_n == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_lat <= '0;
      b_lat <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef CLA_OVERFLOW_EN
      ovf   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_lat <= ain;
            b_lat <= bin;
            carry <= cin;
            idx   <= '0;
          end
        end
        CALC: begin
          sum[idx*BLOCK +: BLOCK] <= s_sl;
          carry <= co_sl;
          idx   <= idx + CW'(1);
          if (last) begin
            cout <= co_sl;
`ifdef CLA_OVERFLOW_EN
            ovf  <= (a_lat[MSB] == b_lat[MSB]) &&
                    (s_sl[BLOCK-1] != a_lat[MSB]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed bench for cla_seq_adder: 4-bit exhaustive plus 8-bit handshake cases.
module tb_cla_seq_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic       rst4, iv4, ir4, ov4, or4, ci4, co4;
  logic [3:0] a4, b4, s4;
  logic       rst8, iv8, ir8, ov8, or8, ci8, co8;
  logic [7:0] a8, b8, s8;
`ifdef CLA_OVERFLOW_EN
  logic       vf4, vf8;
`endif

  cla_seq_adder #(.nBITS(4), .BLOCK(4)) u_dut4 (
    .clk      (clk),
    .reset    (rst4),
    .in_valid (iv4),
    .in_ready (ir4),
    .ain      (a4),
    .bin      (b4),
    .cin      (ci4),
    .out_valid(ov4),
    .out_ready(or4),
    .sum      (s4),
    .cout     (co4)
`ifdef CLA_OVERFLOW_EN
    ,
    .ovf      (vf4)
`endif
  );

  cla_seq_adder #(.nBITS(8), .BLOCK(4)) u_dut8 (
    .clk      (clk),
    .reset    (rst8),
    .in_valid (iv8),
    .in_ready (ir8),
    .ain      (a8),
    .bin      (b8),
    .cin      (ci8),
    .out_valid(ov8),
    .out_ready(or8),
    .sum      (s8),
    .cout     (co8)
`ifdef CLA_OVERFLOW_EN
    ,
    .ovf      (vf8)
`endif
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b,
                      input logic c);
    logic [4:0] e;
    e = {1'b0, a} + {1'b0, b} + {4'b0, c};
    check("ir4", ir4, 1);
    a4 = a; b4 = b; ci4 = c; iv4 = 1'b1;
    @(negedge clk);
    iv4 = 1'b0;
    @(negedge clk);
    check("res4", {ov4, co4, s4}, {1'b1, e});
    @(negedge clk);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input logic c, input logic [8:0] exp,
                      input int hold, input bit busy);
    int lat;
    check("ir8", ir8, 1);
    a8 = a; b8 = b; ci8 = c; iv8 = 1'b1;
    or8 = (hold == 0);
    @(negedge clk);
    iv8 = 1'b0;
    if (busy) begin
      a8 = ~a; b8 = ~b; ci8 = ~c; iv8 = 1'b1;
    end
    lat = 0;
    while (!ov8 && lat < 20) begin
      @(negedge clk);
      iv8 = 1'b0;
      lat++;
    end
    check("lat8", lat, 2);
    check("res8", {co8, s8}, exp);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_ov", ov8, 1);
      check("hold_res", {co8, s8}, exp);
      check("hold_ir", ir8, 0);
    end
    or8 = 1'b1;
    @(negedge clk);
    check("post_hs8", {ir8, ov8}, 2'b10);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst4 = 1'b1; rst8 = 1'b1;
    iv4 = 1'b0; iv8 = 1'b0; or4 = 1'b1; or8 = 1'b1;
    a4 = '0; b4 = '0; ci4 = 1'b0;
    a8 = '0; b8 = '0; ci8 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst4", {ir4, ov4, co4, s4}, 0);
    check("rst8", {ir8, ov8, co8, s8}, 0);
`ifdef CLA_OVERFLOW_EN
    check("rst_ovf8", vf8, 0);
`endif
    rst4 = 1'b0; rst8 = 1'b0;
    @(negedge clk);
    check("up4", {ir4, ov4}, 2'b10);
    check("up8", {ir8, ov8}, 2'b10);

    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          run4(4'(a), 4'(b), 1'(c));

    run8(8'hFF, 8'h01, 1'b0, 9'h100, 0, 1'b0);
    run8(8'h0F, 8'h00, 1'b1, 9'h010, 0, 1'b0);
    run8(8'hA5, 8'h5A, 1'b1, 9'h100, 5, 1'b0);
    run8(8'h21, 8'h43, 1'b0, 9'h064, 0, 1'b1);
    @(negedge clk);
    check("no_extra", {ir8, ov8}, 2'b10);

    a8 = 8'h99; b8 = 8'h99; ci8 = 1'b0; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    rst8 = 1'b1;
    @(negedge clk);
    check("rst_mid", {ir8, ov8, co8, s8}, 0);
`ifdef CLA_OVERFLOW_EN
    check("rst_mid_ovf", vf8, 0);
`endif
    rst8 = 1'b0;
    @(negedge clk);
    check("rst_mid_up", {ir8, ov8}, 2'b10);
    run8(8'h12, 8'h34, 1'b0, 9'h046, 0, 1'b0);

`ifdef CLA_OVERFLOW_EN
    run8(8'h7F, 8'h01, 1'b0, 9'h080, 0, 1'b0);
    check("ovf_7f", vf8, 1);
    run8(8'h80, 8'h80, 1'b0, 9'h100, 0, 1'b0);
    check("ovf_80", vf8, 1);
    run8(8'h01, 8'h01, 1'b0, 9'h002, 0, 1'b0);
    check("ovf_01", vf8, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cla_seq_adder.md
# cla_seq_adder

Sequential, handshaked N-bit adder. It accepts one operand pair plus carry-in per transaction and computes the sum one BLOCK-bit carry-lookahead slice per clock, rippling the carry through a register. It returns {cout, sum} on a valid/ready output port. It is the design-side responder for the team's adder stimulus/checker benches, and the registered adder used wherever a full-width single-cycle CLA does not meet timing.

## Interface
Parameters:
- nBITS, 4: operand and sum width; must be a positive multiple of BLOCK.
- BLOCK, 4: slice width handled per cycle by one CLA block.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  block can accept operands.
- ain  input  nBITS  operand A.
- bin  input  nBITS  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- sum  output  nBITS  ain+bin+cin, low nBITS bits.
- cout  output  1  carry-out, bit nBITS of the sum.
- ovf  output  1  signed overflow; present only with CLA_OVERFLOW_EN.

## Operation
- NBLK = nBITS/BLOCK. If nBITS % BLOCK != 0 or nBITS == 0, elaboration fails with $error.
- FSM states: IDLE, CALC, DONE.
  - IDLE: in_ready=1. When in_valid, ain, bin and cin are latched, slice counter is cleared, carry register is set to cin, and the FSM goes to CALC.
  - CALC: each cycle slice i computes a_lat[i*BLOCK +: BLOCK] + b_lat[...] + carry. It writes sum[i*BLOCK +: BLOCK], stores the slice carry-out into the carry register, and increments i. After slice NBLK-1 completes, cout takes the final carry and the FSM goes to DONE.
  - DONE: out_valid=1. sum and cout hold stable. When out_ready, the FSM goes to IDLE.
- Inputs ain, bin, cin and in_valid are ignored outside IDLE. Operands are latched, so changing them mid-CALC has no effect.
- Arithmetic is unsigned and modulo 2^(nBITS+1); {cout,sum} == ain+bin+cin exactly.
- sum and cout are registered. They keep the last result through IDLE until overwritten during the next CALC.
- Reset values: in_ready=0 while reset is high and 1 from the first cycle after it deasserts. out_valid=0, sum=0, cout=0, ovf=0, state=IDLE, carry register=0.
- Reset mid-operation in CALC or DONE aborts the transaction. No result is delivered and all outputs return to reset values.

## Timing
- Accept at edge E0 (in_valid && in_ready). out_valid rises after edge E0+NBLK, so latency is NBLK cycles: nBITS=4 gives 1 cycle, nBITS=8 gives 2.
- Transfer at edge E1 (out_valid && out_ready). in_ready rises after E1, so the next accept is possible at E1+1.
- Peak throughput is one result per NBLK+2 cycles.
- out_ready held low keeps the block in DONE indefinitely, with outputs stable.
- in_ready and out_valid are never high in the same cycle.
- in_ready and out_valid depend only on state, never combinationally on in_valid or out_ready.

## Configuration
- CLA_OVERFLOW_EN defined: port ovf exists. On entry to DONE it is set to (a_lat[MSB] == b_lat[MSB]) && (sum[MSB] != a_lat[MSB]), i.e. two's-complement overflow. It holds with the result and is 0 in reset.
- CLA_OVERFLOW_EN undefined: the ovf port, its register and logic are absent. All other behaviour is identical.

## Structure
- Package cla_pkg:
  - typedef enum logic [1:0] {IDLE, CALC, DONE} cla_state_t;
  - default width constants.
  - function nblk(nbits, block).
- Sub-module cla_block: combinational BLOCK-bit carry-lookahead slice with ports a, b, ci, s, co. Internally it uses generate/propagate terms g=a&b and p=a^b, with lookahead carries c[k+1]=g[k]|p[k]&c[k] expanded in sum-of-products form. It is instantiated once in cla_seq_adder and fed by the slice-select mux.
- The slice counter is $clog2(NBLK)+1 bits wide, so it covers NBLK=1.

## Test plan
- nBITS=4, exhaustive: all ain, bin in 0..15 for cin=0 then 1 (512 transactions), out_ready=1 -> {cout,sum}==ain+bin+cin every time, out_valid 1 cycle after accept.
- nBITS=8, BLOCK=4: ain=0xFF, bin=0x01, cin=0 -> sum=0x00, cout=1, out_valid exactly 2 cycles after accept. Then 0x0F+0x00+cin=1 -> sum=0x10, cout=0, which checks the inter-slice carry.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_valid, sum and cout stable and in_ready=0 throughout. Raise out_ready -> in_ready=1 the cycle after.
- Busy input: change ain/bin and pulse in_valid during CALC -> result reflects the latched operands, with no extra transaction.
- Reset mid-CALC (nBITS=8, assert reset one cycle after accept) -> next cycle out_valid=0, sum=0, cout=0. in_ready=1 after reset deasserts. A new 0x12+0x34 then yields 0x46.
- With CLA_OVERFLOW_EN, nBITS=8: 0x7F+0x01 -> ovf=1; 0x80+0x80 -> ovf=1, cout=1, sum=0x00; 0x01+0x01 -> ovf=0.
